// File: rtl/zx_sound_pkg.sv
// Shared widths, reset constants and types for the multisound DAC path.
package zx_sound_pkg;
    localparam int SAMPLE_W = 8;
    localparam int VOL_W    = 6;
    localparam int VOL_MAX  = 63;
    localparam logic [SAMPLE_W-1:0] SAMPLE_MID = 8'h80;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Right-shifting Galois mask for x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef logic [SAMPLE_W-1:0] sample_t;
    typedef logic [VOL_W-1:0]    vol_t;
endpackage

// File: rtl/zx_dac_channel.sv
// One DAC channel: double-buffered sample/volume, volume gate, first-order
// sigma-delta accumulator and the midscale idle toggle used while gated off.
module zx_dac_channel
    import zx_sound_pkg::*;
(
    input  logic    clk32,
    input  logic    rst_n,
    input  vol_t    vol_cnt,
    input  logic    boundary,
    input  logic    dither_bit,
    input  sample_t sample_in,
    input  logic    sample_wr,
    input  vol_t    vol_in,
    input  logic    vol_wr,
    output logic    dac_out
);
    sample_t    shadow_sample, active_sample, acc;
    vol_t       shadow_vol, active_vol;
    logic       idle_tog;
    logic       en;
    logic [8:0] sum;
    sample_t    next_shadow_sample;
    vol_t       next_shadow_vol;

    // A strobe on the boundary cycle bypasses straight into the active copy.
    assign next_shadow_sample = sample_wr ? sample_in : shadow_sample;
    assign next_shadow_vol    = vol_wr    ? vol_in    : shadow_vol;

    assign en  = (vol_cnt < active_vol) || (active_vol == vol_t'(VOL_MAX));
    assign sum = {1'b0, acc} + {1'b0, active_sample} + {8'b0, dither_bit};

    always_ff @(posedge clk32 or negedge rst_n) begin
        if (!rst_n) begin
            shadow_sample <= SAMPLE_MID;
            active_sample <= SAMPLE_MID;
            shadow_vol    <= '0;
            active_vol    <= '0;
            acc           <= '0;
            idle_tog      <= 1'b0;
            dac_out       <= 1'b0;
        end else begin
            shadow_sample <= next_shadow_sample;
            shadow_vol    <= next_shadow_vol;
            if (boundary) begin
                active_sample <= next_shadow_sample;
                active_vol    <= next_shadow_vol;
            end
            if (en) begin
                acc     <= sum[7:0];
                dac_out <= sum[8];
            end else begin
                idle_tog <= ~idle_tog;
                dac_out  <= idle_tog;
            end
        end
    end
endmodule

// File: rtl/zx_dac_modulator.sv
// Multichannel sigma-delta DAC with volume time-gating.
// Define ZX_DAC_DITHER_EN to add LFSR carry-in dither to every channel.
module zx_dac_modulator
    import zx_sound_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int VOL_STEP = 31
) (
    input  logic                         clk32,
    input  logic                         rst_n,
    input  logic [SAMPLE_W*CHANNELS-1:0] sample_in,
    input  logic [CHANNELS-1:0]          sample_wr,
    input  logic [VOL_W*CHANNELS-1:0]    vol_in,
    input  logic [CHANNELS-1:0]          vol_wr,
    output logic [CHANNELS-1:0]          dac_out,
    output logic                         frame_tick
);
    vol_t                vol_cnt;
    logic                boundary;
    logic [CHANNELS-1:0] dither;

    assign boundary = (vol_cnt == '0);

    // Odd step makes vol_cnt a full 64-cycle permutation, so each frame
    // presents every phase exactly once to the gate compare.
    always_ff @(posedge clk32 or negedge rst_n) begin
        if (!rst_n) begin
            vol_cnt    <= '0;
            frame_tick <= 1'b0;
        end else begin
            vol_cnt    <= vol_cnt + vol_t'(VOL_STEP);
            frame_tick <= boundary;
        end
    end

`ifdef ZX_DAC_DITHER_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk32 or negedge rst_n) begin
        if (!rst_n) lfsr <= LFSR_SEED;
        else        lfsr <= {1'b0, lfsr[15:1]} ^ ({16{lfsr[0]}} & LFSR_TAPS);
    end
`endif

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
`ifdef ZX_DAC_DITHER_EN
        assign dither[g] = lfsr[g % 16];
`else
        assign dither[g] = 1'b0;
`endif
        zx_dac_channel u_ch (
            .clk32      (clk32),
            .rst_n      (rst_n),
            .vol_cnt    (vol_cnt),
            .boundary   (boundary),
            .dither_bit (dither[g]),
            .sample_in  (sample_in[g*SAMPLE_W +: SAMPLE_W]),
            .sample_wr  (sample_wr[g]),
            .vol_in     (vol_in[g*VOL_W +: VOL_W]),
            .vol_wr     (vol_wr[g]),
            .dac_out    (dac_out[g])
        );
    end
endmodule

// File: tb/tb_zx_dac_modulator.sv
// Directed + randomized bench for zx_dac_modulator against a per-cycle
// arithmetic reference model of frames, gating and the sigma-delta sum.
module tb_zx_dac_modulator;
    localparam int CH = 4;

    logic            clk32 = 1'b0;
    logic            rst_n;
    logic [8*CH-1:0] sample_in;
    logic [CH-1:0]   sample_wr;
    logic [6*CH-1:0] vol_in;
    logic [CH-1:0]   vol_wr;
    logic [CH-1:0]   dac_out;
    logic            frame_tick;

    int n_assert = 0;
    int n_fail   = 0;

    // reference model state
    int       m_cnt;
    int       m_sh_s[CH], m_ac_s[CH], m_sh_v[CH], m_ac_v[CH], m_acc[CH];
    bit       m_tog[CH];
    bit [CH-1:0] m_out;
    bit       m_tick;

    zx_dac_modulator #(.CHANNELS(CH), .VOL_STEP(31)) dut (
        .clk32      (clk32),
        .rst_n      (rst_n),
        .sample_in  (sample_in),
        .sample_wr  (sample_wr),
        .vol_in     (vol_in),
        .vol_wr     (vol_wr),
        .dac_out    (dac_out),
        .frame_tick (frame_tick)
    );

    always #5 clk32 = ~clk32;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt  = 0;
        m_out  = '0;
        m_tick = 1'b0;
        for (int c = 0; c < CH; c++) begin
            m_sh_s[c] = 128; m_ac_s[c] = 128;
            m_sh_v[c] = 0;   m_ac_v[c] = 0;
            m_acc[c]  = 0;   m_tog[c]  = 1'b0;
        end
    endtask

    // One clock of the reference: output from pre-edge state, then writes,
    // then frame transfer of the (possibly just written) shadow values.
    task automatic model_step();
        bit bnd;
        int t;
        bnd = (m_cnt == 0);
        for (int c = 0; c < CH; c++) begin
            if (m_cnt < m_ac_v[c] || m_ac_v[c] == 63) begin
                t         = m_acc[c] + m_ac_s[c];
                m_out[c]  = (t >= 256);
                m_acc[c]  = t % 256;
            end else begin
                m_out[c]  = m_tog[c];
                m_tog[c]  = !m_tog[c];
            end
            if (sample_wr[c]) m_sh_s[c] = int'(sample_in[8*c +: 8]);
            if (vol_wr[c])    m_sh_v[c] = int'(vol_in[6*c +: 6]);
            if (bnd) begin
                m_ac_s[c] = m_sh_s[c];
                m_ac_v[c] = m_sh_v[c];
            end
        end
        m_tick = bnd;
        m_cnt  = (m_cnt + 31) % 64;
    endtask

    task automatic cycle();
        @(posedge clk32);
        model_step();
        #1;
        check("dac_out", 32'(dac_out), 32'(m_out));
        check("frame_tick", 32'(frame_tick), 32'(m_tick));
        sample_wr = '0;
        vol_wr    = '0;
    endtask

    task automatic wr(int c, int s, int v, bit ws, bit wv);
        logic [7:0] sv;
        logic [5:0] vv;
        sv = s[7:0];
        vv = v[5:0];
        sample_in[8*c +: 8] = sv;
        vol_in[6*c +: 6]    = vv;
        sample_wr[c]        = ws;
        vol_wr[c]           = wv;
    endtask

    task automatic wait_tick(string tag);
        int k;
        k = 0;
        do begin
            cycle();
            k++;
        end while (!frame_tick && k < 70);
        check(tag, 32'(frame_tick), 32'd1);
    endtask

    task automatic count_ones(int c, int n, output int ones, output bit alt);
        logic prev;
        ones = 0;
        alt  = 1'b1;
        prev = 1'b0;
        for (int i = 0; i < n; i++) begin
            cycle();
            ones += int'(dac_out[c]);
            if (i > 0 && dac_out[c] == prev) alt = 1'b0;
            prev = dac_out[c];
        end
    endtask

    initial begin
        int  ones, k, k2;
        bit  alt;
        rst_n = 1'b0;
        sample_in = '0; sample_wr = '0; vol_in = '0; vol_wr = '0;
        model_reset();
        #12;
        check("reset_dac_out", 32'(dac_out), 32'd0);
        check("reset_frame_tick", 32'(frame_tick), 32'd0);
        @(negedge clk32);
        rst_n = 1'b1;

        // full volume, midscale: strictly alternating 50 %
        wr(0, 8'h80, 63, 1'b1, 1'b1);
        wait_tick("t1_tick");
        count_ones(0, 256, ones, alt);
        check("t1_ones", ones, 128);
        check("t1_alternate", 32'(alt), 32'd1);

        // full volume extremes
        wr(0, 8'hFF, 63, 1'b1, 1'b0);
        wait_tick("t2_tick_ff");
        count_ones(0, 256, ones, alt);
        check("t2_ff_ones", ones, 255);
        wr(0, 8'h00, 63, 1'b1, 1'b0);
        wait_tick("t2_tick_00");
        count_ones(0, 256, ones, alt);
        check("t2_00_ones", ones, 0);

        // muted: idle toggle only
        wr(0, int'($urandom_range(0, 255)), 0, 1'b1, 1'b1);
        wait_tick("t3_tick");
        count_ones(0, 64, ones, alt);
        check("t3_ones", ones, 32);
        check("t3_alternate", 32'(alt), 32'd1);

        // half volume
        wr(0, 8'h00, 32, 1'b1, 1'b1);
        wait_tick("t4_tick_00");
        count_ones(0, 64, ones, alt);
        check("t4_00_ones", ones, 16);
        wr(0, 8'hFF, 32, 1'b1, 1'b0);
        wait_tick("t4_tick_ff");
        count_ones(0, 512, ones, alt);
        check("t4_ff_8frames_in_range", 32'(ones >= 381 && ones <= 383), 32'd1);

        // mid-frame write is held until the next boundary
        wr(0, 8'h80, 63, 1'b1, 1'b1);
        wait_tick("t5_tick_a");
        for (int i = 0; i < 20; i++) cycle();
        wr(0, 8'h00, 63, 1'b1, 1'b0);
        ones = 0;
        k = 0;
        do begin
            cycle();
            ones += int'(dac_out[0]);
            k++;
        end while (!frame_tick && k < 70);
        check("t5_tick_b", 32'(frame_tick), 32'd1);
        check("t5_old_sample_until_tick", 32'(ones > 10), 32'd1);
        count_ones(0, 32, ones, alt);
        check("t5_new_sample_after_tick", ones, 0);

        // write landing on the boundary cycle bypasses into active
        k = 0;
        while (m_cnt != 0 && k < 70) begin
            cycle();
            k++;
        end
        check("t5_found_boundary", m_cnt, 0);
        wr(0, 8'hFF, 63, 1'b1, 1'b0);
        cycle();
        count_ones(0, 256, ones, alt);
        check("t5_bypass_ones", ones, 255);

        // async reset mid-frame with all channels active
        for (int c = 0; c < CH; c++) wr(c, int'($urandom_range(0, 255)), 63, 1'b1, 1'b1);
        wait_tick("t6_tick");
        for (int i = 0; i < 10; i++) cycle();
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_reset_dac_out", 32'(dac_out), 32'd0);
        check("t6_reset_frame_tick", 32'(frame_tick), 32'd0);
        model_reset();
        @(posedge clk32);
        @(negedge clk32);
        rst_n = 1'b1;
        k = 0;
        do begin cycle(); k++; end while (!frame_tick && k < 70);
        k2 = 0;
        ones = 0;
        do begin cycle(); k2++; ones += int'(dac_out[3]); end while (!frame_tick && k2 < 70);
        check("t6_frame_interval", k2, 64);
        check("t6_muted_ch3_ones", ones, 32);

        // randomized traffic on all channels
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 7) == 0) begin
                    int v;
                    case ($urandom_range(0, 3))
                        0: v = 0;
                        1: v = 63;
                        default: v = int'($urandom_range(0, 63));
                    endcase
                    wr(c, int'($urandom_range(0, 255)), v,
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                end
            end
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
